memory_read_ctrl: RTL

Reads a stored frame out of the shared cell memory and frees each cell as it drains. Given a head block index, it walks the linked list of cells on read port B of the dual-port memory. Each cell holds a 448-bit payload plus a footer. The payload is serialised as 64-bit beats onto a valid/ready stream with begin/end markers, and each drained block index is returned to the free list. It is the egress counterpart of the memory write controller that fills cells on port A.

---
 rtl/memory_read_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/memory_read_ctrl.sv
// memory_read_ctrl: walks a linked list of cells on memory port B, streams
// each 448-bit payload as 64-bit beats and returns drained cells to the free list.
module memory_read_ctrl #(
  parameter int ADDR_W         = 10,
  parameter int PAYLOAD_BITS   = 448,
  parameter int FOOTER_BITS    = 16,
  parameter int BEATS_PER_CELL = 7,
  localparam int BLOCK_BITS    = PAYLOAD_BITS + FOOTER_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_req_i,
  input  logic [ADDR_W-1:0]     rd_head_idx_i,
  output logic                  rd_ack_o,
  output logic                  mem_en_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  input  logic [BLOCK_BITS-1:0] mem_rdata_i,
  output logic [63:0]           data_o,
  output logic                  data_valid_o,
  output logic                  data_begin_o,
  output logic                  data_end_o,
  input  logic                  data_ready_i,
  output logic                  fl_free_req_o,
  output logic [ADDR_W-1:0]     fl_free_idx_o,
  input  logic                  fl_free_gnt_i,
  output logic                  err_invalid_o
);

  // Footer field positions (footer sits in the block LSBs, payload above it)
  localparam int NEXT_LSB  = FOOTER_BITS - ADDR_W;
  localparam int EOP_BIT   = NEXT_LSB - 1;
  localparam int VALID_BIT = NEXT_LSB - 2;
  localparam int LB_MSB    = NEXT_LSB - 3;
  localparam logic [2:0] LIM_MAX = 3'(BEATS_PER_CELL - 1);

  typedef enum logic [1:0] {IDLE, FETCH, CAPTURE, STREAM} state_t;

  state_t                  state;
  logic [ADDR_W-1:0]       cur_idx;
  logic [ADDR_W-1:0]       next_idx;
  logic [PAYLOAD_BITS-1:0] payload;
  logic                    eop;
  logic [2:0]              last_beat;
  logic [2:0]              beat_cnt;
  logic                    first;
  logic                    slot_full;
  logic [ADDR_W-1:0]       slot_idx;

  logic [2:0]  lim;
  logic        last_hit;
  logic        beat_fire;
  logic        last_fire;
  logic [63:0] beat_words [8];
  logic        unused_rsvd;

  // Split the captured payload into beats, beat 0 taken from the MSBs
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_beat
      if (gi < BEATS_PER_CELL) begin : g_used
        assign beat_words[gi] = payload[PAYLOAD_BITS-1-64*gi -: 64];
      end else begin : g_pad
        assign beat_words[gi] = '0;
      end
    end
  endgenerate

  assign unused_rsvd = &{1'b0, mem_rdata_i[LB_MSB-3:0]};

  // Final beat index of the current cell; oversized last_beat clamps
  assign lim       = eop ? ((last_beat > LIM_MAX) ? LIM_MAX : last_beat) : LIM_MAX;
  assign last_hit  = (beat_cnt == lim);
  assign beat_fire = data_valid_o && data_ready_i;
  assign last_fire = beat_fire && last_hit;

  // Outputs are decoded from state registers only (plus request/read data)
  assign rd_ack_o      = (state == IDLE) && rd_req_i;
  assign mem_en_o      = (state == FETCH);
  assign mem_addr_o    = cur_idx;
  assign err_invalid_o = (state == CAPTURE) && !mem_rdata_i[VALID_BIT];
  // The last beat of a cell waits until the free slot can take its index
  assign data_valid_o  = (state == STREAM) && (!last_hit || !slot_full);
  assign data_o        = (state == STREAM) ? beat_words[beat_cnt] : '0;
  assign data_begin_o  = (state == STREAM) && first && (beat_cnt == 3'd0);
  assign data_end_o    = (state == STREAM) && eop && last_hit;
  assign fl_free_req_o = slot_full;
  assign fl_free_idx_o = slot_idx;

  // Frame walk: fetch a cell, capture it, stream its beats, follow next_idx
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_idx   <= '0;
      next_idx  <= '0;
      payload   <= '0;
      eop       <= 1'b0;
      last_beat <= '0;
      beat_cnt  <= '0;
      first     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_req_i) begin
            cur_idx <= rd_head_idx_i;
            first   <= 1'b1;
            state   <= FETCH;
          end
        end
        FETCH: state <= CAPTURE;
        CAPTURE: begin
          payload   <= mem_rdata_i[BLOCK_BITS-1 -: PAYLOAD_BITS];
          next_idx  <= mem_rdata_i[FOOTER_BITS-1 -: ADDR_W];
          eop       <= mem_rdata_i[EOP_BIT];
          last_beat <= mem_rdata_i[LB_MSB -: 3];
          beat_cnt  <= '0;
          state     <= mem_rdata_i[VALID_BIT] ? STREAM : IDLE;
        end
        STREAM: begin
          if (beat_fire) begin
            first <= 1'b0;
            if (last_hit) begin
              if (eop) begin
                state <= IDLE;
              end else begin
                cur_idx <= next_idx;
                state   <= FETCH;
              end
            end else begin
              beat_cnt <= beat_cnt + 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Single-entry free slot; a new load takes priority over a same-cycle grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_full <= 1'b0;
      slot_idx  <= '0;
    end else if (last_fire) begin
      slot_full <= 1'b1;
      slot_idx  <= cur_idx;
    end else if (fl_free_gnt_i) begin
      slot_full <= 1'b0;
    end
  end

endmodule
